control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port IR, input, 32 bits: instruction register contents; opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
REQ-004 SHALL have port Mem_ready, input, 1 bit: memory read data is valid this cycle.
REQ-005 SHALL have port Stop, input, 1 bit: request to halt at the next instruction boundary.
REQ-006 SHALL have ports Rin and Rout, output, 16 bits each: one-hot general-register load and drive enables.
REQ-007 SHALL have ports PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin, output, 1 bit each: datapath strobes.
REQ-008 SHALL have port ALU_op, output, 5 bits: equal to IR[31:27] whenever Zin is asserted in an execute state, 0 otherwise.
REQ-009 SHALL have ports Run and Illegal, output, 1 bit each: Run = executing; Illegal = halted on an undefined opcode.

Function
REQ-010 SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; outputs decode from state and IR only.
REQ-011 SHALL move IDLE->T0 on the first clock after Reset deasserts.
REQ-012 SHALL assert in T0: PCout, MARin, IncPC, Zin; next state T1.
REQ-013 SHALL assert in T1: ZLOout, PCin, Read, MDRin; PCin only in the first T1 cycle; SHALL hold T1 with Read and MDRin high while Mem_ready=0; SHALL leave for T2 on the cycle Mem_ready=1.
REQ-014 SHALL assert in T2: MDRout, IRin; next state T3.
REQ-015 SHALL decode in T3: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01111, DIV 10000, NOP 11010, HALT 11011; any other opcode is illegal.
REQ-016 SHALL, for ALU ops in T3, assert Rout[Rb] and Yin; in T4, assert Rout[Rc], Zin, ALU_op; in T5, assert ZLOout and Rin[Ra]; then return to T0.
REQ-017 SHALL, for MUL/DIV, use T3 = Rout[Ra], Yin; T4 = Rout[Rb], Zin, ALU_op; T5 = ZLOout, LOin; T6 = ZHIout, HIin; then return to T0.
REQ-018 SHALL, for NOP, go T3->T0 with no strobes in T3.
REQ-019 SHALL, for HALT or an illegal opcode, go T3->HALT; Illegal=1 only for illegal opcodes.
REQ-020 SHALL hold HALT until Reset; all strobes 0 and Run=0 in HALT.
REQ-021 SHALL sample Stop only in the last state of an instruction; Stop=1 there SHALL give HALT instead of T0.
REQ-022 SHALL keep Rin and Rout at zero or exactly one hot bit in every cycle; at most one bus driver is active per cycle.
REQ-023 SHALL assert Run in T0-T6 only.

Reset
REQ-024 SHALL on Reset=1 immediately enter IDLE, including mid-instruction or in HALT; all outputs 0, including Run, Illegal and ALU_op.
REQ-025 SHALL drop any partially executed instruction on reset; Illegal clears only on reset.

Structure
REQ-026 SHALL place the opcode constants and the state encoding in a shared package, cpu_pkg.
REQ-027 SHALL use one sub-module, reg_decoder (4-bit to 16-bit one-hot with enable), instantiated for Rin and Rout.

Verification
REQ-028 SHALL test: IR=0x48918000 (AND R1,R2,R3), Mem_ready=1 -> T0..T5 in 6 cycles; T4: Rout=0x0008, ALU_op=01001; T5: Rin=0x0002.
REQ-029 SHALL test: Mem_ready low for 3 cycles in T1 -> T1 lasts 4 cycles; Read=1 throughout; PCin=1 only in the first cycle.
REQ-030 SHALL test: MUL opcode 01111 -> T5 gives ZLOout+LOin, T6 gives ZHIout+HIin, then T0.
REQ-031 SHALL test: opcode 11111 -> HALT with Illegal=1, Run=0; stays there until Reset.
REQ-032 SHALL test: Reset pulse during T4 -> outputs 0 the same cycle; IDLE then T0 after release.
REQ-033 SHALL test: Stop=1 during T4 of an ADD -> T5 completes, then HALT with Illegal=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Opcode constants, FSM state encoding and opcode classification shared by the
// control unit and its bench-facing decode.
package cpu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_MULDIV,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   function automatic op_class_t classify(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL,
         OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_ALU;
         OP_MUL, OP_DIV:                 return CLS_MULDIV;
         OP_NOP:                         return CLS_NOP;
         OP_HALT:                        return CLS_HALT;
         default:                        return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/reg_decoder.sv
// 4-bit register number to 16-bit one-hot enable; all zeros when not enabled.
module reg_decoder (
   input  logic        en,
   input  logic [3:0]  sel,
   output logic [15:0] onehot
);

   assign onehot = en ? (16'h0001 << sel) : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// Moore-style multi-cycle CPU control unit: fetch (T0-T2), decode/execute (T3-T6),
// with halt on HALT, illegal opcode, or a Stop request at an instruction boundary.
module control_unit
   import cpu_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] IR,
   input  logic        Mem_ready,
   input  logic        Stop,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Zin,
   output logic        ZLOout,
   output logic        ZHIout,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  ALU_op,
   output logic        Run,
   output logic        Illegal
);

   state_t     state, state_next;
   logic       t1_waiting;
   logic       illegal_q;
   op_class_t  cls;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       rin_en, rout_en;
   logic [3:0] rin_sel, rout_sel;
   logic       unused_ir_bits;

   assign opcode         = IR[31:27];
   assign ra             = IR[26:23];
   assign rb             = IR[22:19];
   assign rc             = IR[18:15];
   assign cls            = classify(opcode);
   assign unused_ir_bits = ^IR[14:0];

   // t1_waiting marks T1 cycles after the first, so PCin pulses exactly once per fetch.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= ST_IDLE;
         t1_waiting <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the same pre-edge values.
         state      <= state_next;
         t1_waiting <= (state == ST_T1) && !Mem_ready;
         if (state == ST_T3 && cls == CLS_ILLEGAL)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_next = state;
      PCout  = 1'b0;  MARin  = 1'b0;  IncPC  = 1'b0;  Zin   = 1'b0;
      ZLOout = 1'b0;  ZHIout = 1'b0;  PCin   = 1'b0;  Read  = 1'b0;
      MDRin  = 1'b0;  MDRout = 1'b0;  IRin   = 1'b0;  Yin   = 1'b0;
      HIin   = 1'b0;  LOin   = 1'b0;
      ALU_op = 5'd0;
      rin_en = 1'b0;  rin_sel  = 4'd0;
      rout_en = 1'b0; rout_sel = 4'd0;

      case (state)
         ST_IDLE: state_next = ST_T0;
         ST_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            state_next = ST_T1;
         end
         ST_T1: begin
            ZLOout = 1'b1; Read = 1'b1; MDRin = 1'b1;
            PCin   = !t1_waiting;
            state_next = Mem_ready ? ST_T2 : ST_T1;
         end
         ST_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            state_next = ST_T3;
         end
         ST_T3: begin
            case (cls)
               CLS_ALU: begin
                  rout_en = 1'b1; rout_sel = rb; Yin = 1'b1;
                  state_next = ST_T4;
               end
               CLS_MULDIV: begin
                  rout_en = 1'b1; rout_sel = ra; Yin = 1'b1;
                  state_next = ST_T4;
               end
               CLS_NOP: state_next = Stop ? ST_HALT : ST_T0;
               default: state_next = ST_HALT;
            endcase
         end
         ST_T4: begin
            rout_en  = 1'b1;
            rout_sel = (cls == CLS_MULDIV) ? rb : rc;
            Zin      = 1'b1;
            ALU_op   = opcode;
            state_next = ST_T5;
         end
         ST_T5: begin
            ZLOout = 1'b1;
            if (cls == CLS_MULDIV) begin
               LOin = 1'b1;
               state_next = ST_T6;
            end else begin
               rin_en = 1'b1; rin_sel = ra;
               state_next = Stop ? ST_HALT : ST_T0;
            end
         end
         ST_T6: begin
            ZHIout = 1'b1; HIin = 1'b1;
            state_next = Stop ? ST_HALT : ST_T0;
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_IDLE;
      endcase
   end

   assign Run     = (state inside {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6});
   assign Illegal = illegal_q && (state == ST_HALT);

   reg_decoder u_rin_dec (
      .en     (rin_en),
      .sel    (rin_sel),
      .onehot (Rin)
   );

   reg_decoder u_rout_dec (
      .en     (rout_en),
      .sel    (rout_sel),
      .onehot (Rout)
   );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a hand-written vector table for one AND
// instruction, directed corner sequences, and randomized instructions against a model.
module tb_control_unit;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic [13:0] st;
      logic [4:0]  alu_op;
      logic        run;
      logic        illegal;
   } obs_t;

   typedef struct {
      logic mem_ready;
      logic stop;
      obs_t exp;
   } vec_t;

   // Strobe bit positions inside obs_t.st
   localparam logic [13:0] PCOUT  = 14'h2000;
   localparam logic [13:0] MARIN  = 14'h1000;
   localparam logic [13:0] INCPC  = 14'h0800;
   localparam logic [13:0] ZIN    = 14'h0400;
   localparam logic [13:0] ZLOOUT = 14'h0200;
   localparam logic [13:0] ZHIOUT = 14'h0100;
   localparam logic [13:0] PCIN   = 14'h0080;
   localparam logic [13:0] READ   = 14'h0040;
   localparam logic [13:0] MDRIN  = 14'h0020;
   localparam logic [13:0] MDROUT = 14'h0010;
   localparam logic [13:0] IRIN   = 14'h0008;
   localparam logic [13:0] YIN    = 14'h0004;
   localparam logic [13:0] HIIN   = 14'h0002;
   localparam logic [13:0] LOIN   = 14'h0001;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] IR = 32'd0;
   logic        Mem_ready = 1'b0;
   logic        Stop = 1'b0;
   logic [15:0] Rin, Rout;
   logic        PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read;
   logic        MDRin, MDRout, IRin, Yin, HIin, LOin;
   logic [4:0]  ALU_op;
   logic        Run, Illegal;

   control_unit dut (
      .Clock(Clock), .Reset(Reset), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
      .Rin(Rin), .Rout(Rout), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
      .ZLOout(ZLOout), .ZHIout(ZHIout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
      .ALU_op(ALU_op), .Run(Run), .Illegal(Illegal)
   );

   always #5 Clock = ~Clock;

   int   n_cmp = 0;
   int   n_err = 0;
   obs_t exp_q[$];
   int   mr_q[$];    // 0/1 = required Mem_ready, 2 = don't care
   bit   last_q[$];  // last state of the instruction (where Stop matters)

   function automatic obs_t mk(input logic [15:0] rin, input logic [15:0] rout,
                               input logic [13:0] st, input logic [4:0] op,
                               input logic run, input logic ill);
      obs_t o;
      o.rin = rin; o.rout = rout; o.st = st; o.alu_op = op; o.run = run; o.illegal = ill;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.rin     = Rin;
      o.rout    = Rout;
      o.st      = {PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read,
                   MDRin, MDRout, IRin, Yin, HIin, LOin};
      o.alu_op  = ALU_op;
      o.run     = Run;
      o.illegal = Illegal;
      return o;
   endfunction

   function automatic logic [15:0] bit_of(input logic [3:0] r);
      return 16'h0001 << r;
   endfunction

   // 0 = ALU, 1 = MUL/DIV, 2 = NOP, 3 = HALT, 4 = illegal
   function automatic int kind_of(input logic [4:0] op);
      if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10}) return 0;
      if (op == 5'd15 || op == 5'd16) return 1;
      if (op == 5'd26) return 2;
      if (op == 5'd27) return 3;
      return 4;
   endfunction

   function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
      logic [14:0] low;
      low = 15'($urandom);
      return {op, ra, rb, rc, low};
   endfunction

   task automatic check(input string name, input obs_t got, input obs_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got rin=%h rout=%h st=%b alu_op=%b run=%b illegal=%b / want rin=%h rout=%h st=%b alu_op=%b run=%b illegal=%b",
                  name, got.rin, got.rout, got.st, got.alu_op, got.run, got.illegal,
                  exp.rin, exp.rout, exp.st, exp.alu_op, exp.run, exp.illegal);
      end
   endtask

   task automatic push(input obs_t o, input int mr, input bit last);
      exp_q.push_back(o);
      mr_q.push_back(mr);
      last_q.push_back(last);
   endtask

   // Asserts Reset mid-cycle, checks outputs clear at once, releases, checks IDLE,
   // and leaves the DUT in T0 just after a rising edge.
   task automatic do_reset(input string tag);
      Reset = 1'b1;
      #1;
      check({tag, ".rst"}, sample(), '0);
      @(posedge Clock); #1;
      Reset = 1'b0;
      Mem_ready = 1'b0;
      Stop = 1'b0;
      @(negedge Clock);
      check({tag, ".idle"}, sample(), '0);
      @(posedge Clock); #1;
   endtask

   // Runs one instruction starting in T0 and compares every cycle against the model.
   task automatic run_instr(input string tag, input logic [31:0] ir, input int waits,
                            input bit stop_last, input int stop_from, input bit noise,
                            input int abort_at, output bit halted);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      int         kind;
      bit         stop_v, last_stop;
      op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
      kind = kind_of(op);
      halted = 1'b0;
      last_stop = 1'b0;
      exp_q.delete(); mr_q.delete(); last_q.delete();

      push(mk(0, 0, PCOUT | MARIN | INCPC | ZIN, 0, 1, 0), 2, 0);
      for (int k = 0; k <= waits; k++)
         push(mk(0, 0, ZLOOUT | READ | MDRIN | ((k == 0) ? PCIN : 14'h0), 0, 1, 0),
              (k == waits) ? 1 : 0, 0);
      push(mk(0, 0, MDROUT | IRIN, 0, 1, 0), 2, 0);
      case (kind)
         0: begin
            push(mk(0, bit_of(rb), YIN, 0, 1, 0), 2, 0);
            push(mk(0, bit_of(rc), ZIN, op, 1, 0), 2, 0);
            push(mk(bit_of(ra), 0, ZLOOUT, 0, 1, 0), 2, 1);
         end
         1: begin
            push(mk(0, bit_of(ra), YIN, 0, 1, 0), 2, 0);
            push(mk(0, bit_of(rb), ZIN, op, 1, 0), 2, 0);
            push(mk(0, 0, ZLOOUT | LOIN, 0, 1, 0), 2, 0);
            push(mk(0, 0, ZHIOUT | HIIN, 0, 1, 0), 2, 1);
         end
         default: push(mk(0, 0, 14'h0, 0, 1, 0), 2, 1);
      endcase

      IR = ir;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == abort_at) begin
            do_reset({tag, ".abort"});
            return;
         end
         if (mr_q[i] == 2) Mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
         else              Mem_ready = 1'(mr_q[i]);
         if (stop_from >= 0 && i >= stop_from) stop_v = 1'b1;
         else if (last_q[i])                   stop_v = stop_last;
         else                                  stop_v = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         Stop = stop_v;
         if (last_q[i]) last_stop = stop_v;
         @(negedge Clock);
         check($sformatf("%s.c%0d", tag, i), sample(), exp_q[i]);
         @(posedge Clock); #1;
      end
      Stop = 1'b0;
      halted = (kind >= 3) || last_stop;
      if (halted) begin
         for (int h = 0; h < 3; h++) begin
            Mem_ready = 1'($urandom_range(0, 1));
            Stop      = 1'($urandom_range(0, 1));
            @(negedge Clock);
            check($sformatf("%s.halt%0d", tag, h), sample(), mk(0, 0, 14'h0, 0, 0, kind == 4));
            @(posedge Clock); #1;
         end
         Stop = 1'b0;
      end
   endtask

   vec_t        tbl[6];
   bit          h;
   logic [4:0]  rnd_ops[11] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd15, 5'd16, 5'd26};
   logic [4:0]  bad_ops[7]  = '{5'd0, 5'd1, 5'd2, 5'd11, 5'd14, 5'd20, 5'd31};

   initial begin
      // AND R1,R2,R3 with memory always ready: T0..T5 in six cycles
      tbl[0] = '{1'b1, 1'b0, mk(16'h0000, 16'h0000, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1, 0)};
      tbl[1] = '{1'b1, 1'b0, mk(16'h0000, 16'h0000, ZLOOUT | PCIN | READ | MDRIN, 5'd0, 1, 0)};
      tbl[2] = '{1'b1, 1'b0, mk(16'h0000, 16'h0000, MDROUT | IRIN, 5'd0, 1, 0)};
      tbl[3] = '{1'b1, 1'b0, mk(16'h0000, 16'h0004, YIN, 5'd0, 1, 0)};
      tbl[4] = '{1'b1, 1'b0, mk(16'h0000, 16'h0008, ZIN, 5'b01001, 1, 0)};
      tbl[5] = '{1'b1, 1'b0, mk(16'h0002, 16'h0000, ZLOOUT, 5'd0, 1, 0)};

      do_reset("init");

      IR = 32'h4891_8000;
      for (int i = 0; i < 6; i++) begin
         Mem_ready = tbl[i].mem_ready;
         Stop      = tbl[i].stop;
         @(negedge Clock);
         check($sformatf("and_tbl.c%0d", i), sample(), tbl[i].exp);
         @(posedge Clock); #1;
      end

      run_instr("mem_wait", mkir(5'd3, 4'd4, 4'd5, 4'd6), 3, 0, -1, 0, -1, h);
      run_instr("mul", mkir(5'd15, 4'd7, 4'd8, 4'd9), 0, 0, -1, 0, -1, h);
      run_instr("div", mkir(5'd16, 4'd15, 4'd0, 4'd1), 1, 0, -1, 0, -1, h);
      run_instr("nop", mkir(5'd26, 4'd2, 4'd3, 4'd4), 0, 0, -1, 0, -1, h);
      run_instr("rst_t4", mkir(5'd3, 4'd1, 4'd2, 4'd3), 0, 0, -1, 0, 4, h);
      run_instr("after_rst", mkir(5'd4, 4'd10, 4'd11, 4'd12), 0, 0, -1, 0, -1, h);
      run_instr("stop_t4", mkir(5'd3, 4'd5, 4'd6, 4'd7), 0, 1, 4, 0, -1, h);
      do_reset("post_stop");
      run_instr("illegal", mkir(5'd31, 4'd0, 4'd0, 4'd0), 0, 0, -1, 0, -1, h);
      do_reset("post_illegal");
      run_instr("halt_op", mkir(5'd27, 4'd0, 4'd0, 4'd0), 2, 0, -1, 0, -1, h);
      do_reset("post_halt");

      for (int n = 0; n < 60; n++) begin
         int          r;
         logic [4:0]  op;
         r = $urandom_range(0, 15);
         if (r < 13)       op = rnd_ops[$urandom_range(0, 10)];
         else if (r == 13) op = 5'd27;
         else              op = bad_ops[$urandom_range(0, 6)];
         run_instr($sformatf("rnd%0d", n),
                   mkir(op, 4'($urandom), 4'($urandom), 4'($urandom)),
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0), -1, 1, -1, h);
         if (h) do_reset($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
